// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared types and constants for the matrix sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int DW      = 4;
    localparam int MAX_DIM = 2;

    localparam logic [1:0] HDR_R1 = 2'd0;
    localparam logic [1:0] HDR_C1 = 2'd1;
    localparam logic [1:0] HDR_R2 = 2'd2;
    localparam logic [1:0] HDR_C2 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_MAC    = 3'd4,
        S_FLUSH  = 3'd5,
        S_ERR    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/matrix_addr_gen.sv
// ============================================================================
// matrix_addr_gen : i/j/k loop counters and row-major operand addresses
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_addr_gen #(
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [AW:0]   i_r1,
    input  logic [AW:0]   i_c1,
    input  logic [AW:0]   i_c2,
    output logic [AW-1:0] o_a_addr,
    output logic [AW-1:0] o_b_addr,
    output logic [AW-1:0] o_row,
    output logic [AW-1:0] o_col,
    output logic          o_k_first,
    output logic          o_k_last,
    output logic          o_last
);

    logic [AW:0] r_i, r_j, r_k;
    logic        w_j_last, w_i_last;

    assign o_k_first = (r_k == '0);
    assign o_k_last  = (r_k == i_c1 - 1'b1);
    assign w_j_last  = (r_j == i_c2 - 1'b1);
    assign w_i_last  = (r_i == i_r1 - 1'b1);
    assign o_last    = o_k_last && w_j_last && w_i_last;

    // Sums never exceed MAX_DIM*MAX_DIM-1, so the narrowing cast is lossless
    assign o_a_addr = AW'(r_i * i_c1 + r_k);
    assign o_b_addr = AW'(r_k * i_c2 + r_j);
    assign o_row    = AW'(r_i);
    assign o_col    = AW'(r_j);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_en) begin
            if (o_k_last) begin
                r_k <= '0;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_seq_ctrl.sv
// ============================================================================
// matrix_seq_ctrl : host-to-loader replay, dimension check and MAC sequencing
// Rev 1.0
// ============================================================================
`default_nettype none

module matrix_seq_ctrl #(
    parameter int DW      = matrix_pkg::DW,
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int AW      = $clog2(MAX_DIM*MAX_DIM)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ld_valid,
    output logic          ld_ctrl,
    output logic [DW-1:0] ld_data,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          res_valid,
    output logic [AW-1:0] res_row,
    output logic [AW-1:0] res_col,
    output logic          busy,
    output logic          done,
    output logic          err
);

    import matrix_pkg::*;

    localparam int            CW        = AW + 1;
    localparam logic [DW-1:0] C_MAX_DIM = DW'(MAX_DIM);

    state_t        r_state, w_next;
    logic [1:0]    r_hdr_cnt;
    logic [DW-1:0] r_r1, r_c1, r_r2, r_c2;
    logic [CW-1:0] r_cnt;
    logic          r_chk, r_err, r_done;
    logic          r_ld_valid, r_ld_ctrl;
    logic [DW-1:0] r_ld_data;
    logic          r_res_valid;
    logic [AW-1:0] r_res_row, r_res_col;

    logic          w_in_ready, w_xfer, w_start, w_hdr_last, w_hdr_bad, w_load_last, w_mac_en;
    logic          w_k_first, w_k_last, w_last;
    logic [CW-1:0] w_tot_a, w_tot_b, w_tot_sel;
    logic [AW-1:0] w_row, w_col;

    function automatic logic dim_bad(input logic [DW-1:0] v);
        return (v == '0) || (v > C_MAX_DIM);
    endfunction

    // LOAD_A holds off one cycle after the header while the beat totals settle
    assign w_in_ready  = (r_state == S_HDR) || (r_state == S_LOAD_B) ||
                         ((r_state == S_LOAD_A) && !r_chk);
    assign w_xfer      = in_valid && w_in_ready;
    assign w_start     = (r_state == S_IDLE) && start;
    assign w_hdr_last  = (r_state == S_HDR) && w_xfer && (r_hdr_cnt == HDR_C2);
    assign w_hdr_bad   = dim_bad(r_r1) || dim_bad(r_c1) || dim_bad(r_r2) ||
                         dim_bad(in_data) || (r_c1 != r_r2);
    assign w_tot_a     = CW'(r_r1) * CW'(r_c1);
    assign w_tot_b     = CW'(r_r2) * CW'(r_c2);
    assign w_tot_sel   = (r_state == S_LOAD_A) ? w_tot_a : w_tot_b;
    assign w_load_last = (r_cnt == w_tot_sel - 1'b1);
    assign w_mac_en    = (r_state == S_MAC);

    matrix_addr_gen #(.AW(AW)) u_addr_gen (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_clr     (w_start),
        .i_en      (w_mac_en),
        .i_r1      (CW'(r_r1)),
        .i_c1      (CW'(r_c1)),
        .i_c2      (CW'(r_c2)),
        .o_a_addr  (a_addr),
        .o_b_addr  (b_addr),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_k_first (w_k_first),
        .o_k_last  (w_k_last),
        .o_last    (w_last)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_HDR;
            S_HDR:    if (w_hdr_last) w_next = w_hdr_bad ? S_ERR : S_LOAD_A;
            S_LOAD_A: if (w_xfer && w_load_last) w_next = S_LOAD_B;
            S_LOAD_B: if (w_xfer && w_load_last) w_next = S_MAC;
            S_MAC:    if (w_last) w_next = S_FLUSH;
            S_FLUSH:  w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hdr_cnt   <= '0;
            r_r1        <= '0;
            r_c1        <= '0;
            r_r2        <= '0;
            r_c2        <= '0;
            r_cnt       <= '0;
            r_chk       <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_ld_valid  <= 1'b0;
            r_ld_ctrl   <= 1'b0;
            r_ld_data   <= '0;
            r_res_valid <= 1'b0;
            r_res_row   <= '0;
            r_res_col   <= '0;
        end else begin
            r_ld_valid  <= w_xfer;
            r_ld_ctrl   <= w_xfer && (r_state == S_HDR);
            r_ld_data   <= w_xfer ? in_data : '0;
            r_chk       <= w_hdr_last && !w_hdr_bad;
            r_done      <= (r_state == S_FLUSH);
            r_res_valid <= w_mac_en && w_k_last;
            r_res_row   <= (w_mac_en && w_k_last) ? w_row : '0;
            r_res_col   <= (w_mac_en && w_k_last) ? w_col : '0;

            if (w_start) begin
                r_err     <= 1'b0;
                r_hdr_cnt <= '0;
                r_cnt     <= '0;
                r_r1      <= '0;
                r_c1      <= '0;
                r_r2      <= '0;
                r_c2      <= '0;
            end
            if (w_hdr_last && w_hdr_bad) r_err <= 1'b1;

            if ((r_state == S_HDR) && w_xfer) begin
                r_hdr_cnt <= r_hdr_cnt + 1'b1;
                case (r_hdr_cnt)
                    HDR_R1:  r_r1 <= in_data;
                    HDR_C1:  r_c1 <= in_data;
                    HDR_R2:  r_r2 <= in_data;
                    default: r_c2 <= in_data;
                endcase
            end

            if (((r_state == S_LOAD_A) || (r_state == S_LOAD_B)) && w_xfer)
                r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign ld_valid  = r_ld_valid;
    assign ld_ctrl   = r_ld_ctrl;
    assign ld_data   = r_ld_data;
    assign mac_en    = w_mac_en;
    assign mac_clr   = w_mac_en && w_k_first;
    assign res_valid = r_res_valid;
    assign res_row   = r_res_row;
    assign res_col   = r_res_col;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_matrix_seq_ctrl.sv
// ============================================================================
// tb_matrix_seq_ctrl : scoreboard bench for the matrix sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matrix_seq_ctrl;

    localparam int DW      = 4;
    localparam int MAX_DIM = 2;
    localparam int AW      = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, ld_valid, ld_ctrl, mac_clr, mac_en, res_valid, busy, done, err;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] a_addr, b_addr, res_row, res_col;
    logic [20:0]   w_outs;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_ld  [$];
    logic [5:0] exp_mac [$];
    logic [3:0] exp_res [$];
    logic [3:0] fixed_elems [4] = '{4'd1, 4'd15, 4'd2, 4'd2};
    bit         res_due = 1'b0;

    matrix_seq_ctrl #(.DW(DW), .MAX_DIM(MAX_DIM)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ld_valid(ld_valid), .ld_ctrl(ld_ctrl), .ld_data(ld_data),
        .a_addr(a_addr), .b_addr(b_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .res_valid(res_valid), .res_row(res_row), .res_col(res_col),
        .busy(busy), .done(done), .err(err)
    );

    assign w_outs = {in_ready, ld_valid, ld_ctrl, ld_data, a_addr, b_addr, mac_clr, mac_en,
                     res_valid, res_row, res_col, busy, done, err};

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Output monitor: pops scoreboard entries whenever the DUT produces something
    always @(negedge CLK) begin
        logic [5:0] e;
        bit         kl;
        kl = 1'b0;
        if (RST_N) begin
            if (ld_valid) begin
                if (exp_ld.size() == 0) chk("ld_extra", 1, 0);
                else chk("ld_beat", {ld_ctrl, ld_data}, exp_ld.pop_front());
            end
            if (mac_en) begin
                if (exp_mac.size() == 0) chk("mac_extra", 1, 0);
                else begin
                    e  = exp_mac.pop_front();
                    kl = e[5];
                    chk("mac_ctl", {mac_clr, a_addr, b_addr}, e[4:0]);
                end
            end
            if (res_valid || res_due) chk("res_align", res_valid, res_due);
            if (res_valid) begin
                if (exp_res.size() == 0) chk("res_extra", 1, 0);
                else chk("res_coord", {res_row, res_col}, exp_res.pop_front());
            end
            res_due = kl;
        end else begin
            res_due = 1'b0;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic ctrl, input int gap);
        int n;
        n = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge CLK);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
        exp_ld.push_back({ctrl, d});
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic run_job(input int r1, input int c1, input int r2, input int c2,
                           input int gapmax, input int abort_at);
        bit ok;
        int nel, n, nmac;
        ok = (r1 >= 1) && (r1 <= MAX_DIM) && (c1 >= 1) && (c1 <= MAX_DIM) &&
             (r2 >= 1) && (r2 <= MAX_DIM) && (c2 >= 1) && (c2 <= MAX_DIM) && (c1 == r2);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("err_cleared", err, 0);
        chk("busy_hdr", busy, 1);
        if (ok) begin
            for (int i = 0; i < r1; i++)
                for (int j = 0; j < c2; j++) begin
                    for (int k = 0; k < c1; k++)
                        exp_mac.push_back({k == c1 - 1, k == 0, AW'(i * c1 + k), AW'(k * c2 + j)});
                    exp_res.push_back({AW'(i), AW'(j)});
                end
        end
        send(DW'(r1), 1'b1, 0);
        send(DW'(c1), 1'b1, 0);
        send(DW'(r2), 1'b1, 0);
        send(DW'(c2), 1'b1, 0);
        chk("hdr_check_stall", in_ready, 0);
        if (!ok) begin
            chk("err_set", err, 1);
            chk("err_busy", busy, 1);
            chk("err_no_mac", mac_en, 0);
            @(negedge CLK);
            chk("err_idle", {busy, err, in_ready}, 3'b010);
            return;
        end
        nel = r1 * c1 + r2 * c2;
        for (int e = 0; e < nel; e++) begin
            if (e == abort_at) begin
                RST_N = 1'b0;
                #1;
                chk("rst_mid_outs", w_outs, 0);
                exp_ld.delete();
                exp_mac.delete();
                exp_res.delete();
                @(negedge CLK);
                RST_N = 1'b1;
                @(negedge CLK);
                chk("rst_idle", busy, 0);
                return;
            end
            send(fixed_elems[e % 4], 1'b0, (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
        end
        nmac = r1 * c2 * c1;
        n = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("done_latency", n, nmac + 1);
        chk("done_busy", busy, 0);
        chk("ld_left", exp_ld.size(), 0);
        chk("mac_left", exp_mac.size(), 0);
        chk("res_left", exp_res.size(), 0);
        @(negedge CLK);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("reset_outs", w_outs, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        run_job(2, 2, 2, 2, 0, -1);
        run_job(2, 2, 1, 2, 0, -1);
        run_job(0, 2, 2, 2, 0, -1);
        run_job(3, 2, 2, 2, 0, -1);
        run_job(1, 2, 2, 1, 0, -1);
        run_job(2, 2, 2, 2, 2, -1);
        run_job(2, 2, 2, 2, 0, 5);
        run_job(2, 2, 2, 2, 0, -1);
        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
